// File: rtl/idu_stage_if.sv
// idu_stage_if: upstream instruction handshake plus the decoded head-record bus.
// Latency: none, wires only.
// Backpressure: in_ready/out_ready carry valid-ready flow control in each direction.
interface idu_stage_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc_in;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm;
  logic [2:0]      imm_type;
  logic            illegal;
  logic [XLEN-1:0] pc_out;

  // Environment side: feeds instructions, consumes decoded records.
  modport master (
    output in_valid, inst, pc_in, out_ready,
    input  in_ready, out_valid, opcode, funct3, funct7, rs1, rs2, rd,
           imm, imm_type, illegal, pc_out
  );

  // Decode stage side.
  modport slave (
    input  in_valid, inst, pc_in, out_ready,
    output in_ready, out_valid, opcode, funct3, funct7, rs1, rs2, rd,
           imm, imm_type, illegal, pc_out
  );
endinterface

// File: rtl/idu_stage.sv
// idu_stage: RV instruction decoder feeding a 2-entry FIFO of decoded records.
// Latency: 1 cycle from accept to head when the FIFO is empty.
// Backpressure: in_ready = stored count < 2 (no out_ready path); head held stable while stalled.
module idu_stage #(
  parameter int XLEN    = 64,
  parameter bit PASS_PC = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  idu_stage_if.slave bus
);

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_type;
    logic            illegal;
    logic [6:0]      funct7;
    logic [4:0]      rs2;
    logic [4:0]      rs1;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      opcode;
  } rec_t;

  rec_t        dec;
  logic [63:0] imm64;
  rec_t        mem_q [2];
  rec_t        mem_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        push;
  logic        pop;
  logic        head_vld;
  rec_t        head;

  // Combinational decode of the incoming instruction; immediates are built at
  // 64 bits and truncated so the XLEN=32 build needs no zero-width replication.
  always_comb begin
    dec        = '0;
    imm64      = '0;
    dec.opcode = bus.inst[6:0];
    dec.funct3 = bus.inst[14:12];
    dec.funct7 = bus.inst[31:25];
    dec.pc     = PASS_PC ? bus.pc_in : '0;
    if (bus.inst[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      case (bus.inst[6:0])
        OPC_OP_IMM, OPC_JALR, OPC_LOAD, OPC_SYSTEM: begin
          dec.imm_type = IMM_I;
          imm64        = {{52{bus.inst[31]}}, bus.inst[31:20]};
          dec.rd       = bus.inst[11:7];
          dec.rs1      = bus.inst[19:15];
        end
        OPC_OP_IMM_32: begin
          if (XLEN == 64) begin
            dec.imm_type = IMM_I;
            imm64        = {{52{bus.inst[31]}}, bus.inst[31:20]};
            dec.rd       = bus.inst[11:7];
            dec.rs1      = bus.inst[19:15];
          end else begin
            dec.illegal = 1'b1;
          end
        end
        OPC_STORE: begin
          dec.imm_type = IMM_S;
          imm64        = {{52{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
          dec.rs1      = bus.inst[19:15];
          dec.rs2      = bus.inst[24:20];
        end
        OPC_BRANCH: begin
          dec.imm_type = IMM_B;
          imm64        = {{51{bus.inst[31]}}, bus.inst[31], bus.inst[7],
                          bus.inst[30:25], bus.inst[11:8], 1'b0};
          dec.rs1      = bus.inst[19:15];
          dec.rs2      = bus.inst[24:20];
        end
        OPC_LUI, OPC_AUIPC: begin
          dec.imm_type = IMM_U;
          imm64        = {{32{bus.inst[31]}}, bus.inst[31:12], 12'h000};
          dec.rd       = bus.inst[11:7];
        end
        OPC_JAL: begin
          dec.imm_type = IMM_J;
          imm64        = {{43{bus.inst[31]}}, bus.inst[31], bus.inst[19:12],
                          bus.inst[20], bus.inst[30:21], 1'b0};
          dec.rd       = bus.inst[11:7];
        end
        OPC_OP: begin
          dec.imm_type = IMM_NONE;
          dec.rd       = bus.inst[11:7];
          dec.rs1      = bus.inst[19:15];
          dec.rs2      = bus.inst[24:20];
        end
        OPC_OP_32: begin
          if (XLEN == 64) begin
            dec.rd  = bus.inst[11:7];
            dec.rs1 = bus.inst[19:15];
            dec.rs2 = bus.inst[24:20];
          end else begin
            dec.illegal = 1'b1;
          end
        end
        default: dec.illegal = 1'b1;
      endcase
    end
    dec.imm = imm64[XLEN-1:0];
  end

  assign bus.in_ready = (count_q < 2'd2);
  assign head_vld     = (count_q != 2'd0);
  assign bus.out_valid = head_vld;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = head_vld && bus.out_ready;

  // Next-state for the FIFO; flush empties it and wins over accept and pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset empties the FIFO and clears stored records.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head record, forced to zero whenever nothing is valid.
  always_comb begin
    head = '0;
    if (head_vld) begin
      head = mem_q[rd_ptr_q];
    end
  end

  assign bus.opcode   = head.opcode;
  assign bus.funct3   = head.funct3;
  assign bus.funct7   = head.funct7;
  assign bus.rs1      = head.rs1;
  assign bus.rs2      = head.rs2;
  assign bus.rd       = head.rd;
  assign bus.imm      = head.imm;
  assign bus.imm_type = head.imm_type;
  assign bus.illegal  = head.illegal;
  assign bus.pc_out   = head.pc;

endmodule

// File: tb/tb_idu_stage.sv
// tb_idu_stage: drives an RV64 (pc passed) and an RV32 (pc zeroed) idu_stage with
// identical stimulus and compares both against a queue-based reference model.
// Directed scenarios first, then randomized traffic with flush and reset.
module tb_idu_stage;
  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  idu_stage_if #(.XLEN(64)) b64 ();
  idu_stage_if #(.XLEN(32)) b32 ();

  idu_stage #(.XLEN(64), .PASS_PC(1'b1)) u64 (.clk(clk), .rst(rst), .flush(flush), .bus(b64));
  idu_stage #(.XLEN(32), .PASS_PC(1'b0)) u32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } ent_t;

  typedef struct {
    bit     ill;
    int     itype;
    longint imm;
    int     rd;
    int     rs1;
    int     rs2;
  } dec_t;

  ent_t q[$];

  function automatic dec_t ref_decode(input logic [31:0] i, input int xlen);
    dec_t d;
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;
    int f_rd, f_rs1, f_rs2;
    imm_i = i[31:20];
    imm_s = {i[31:25], i[11:7]};
    imm_b = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    imm_u = {i[31:12], 12'h000};
    imm_j = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    f_rd  = int'(i[11:7]);
    f_rs1 = int'(i[19:15]);
    f_rs2 = int'(i[24:20]);
    d.ill = 1'b0; d.itype = 0; d.imm = 0; d.rd = 0; d.rs1 = 0; d.rs2 = 0;
    if (i[1:0] != 2'b11) begin
      d.ill = 1'b1;
    end else begin
      case (i[6:0])
        7'h13, 7'h67, 7'h03, 7'h73: begin d.itype = 1; d.imm = imm_i; d.rd = f_rd; d.rs1 = f_rs1; end
        7'h1B: if (xlen == 64) begin d.itype = 1; d.imm = imm_i; d.rd = f_rd; d.rs1 = f_rs1; end
               else d.ill = 1'b1;
        7'h23: begin d.itype = 2; d.imm = imm_s; d.rs1 = f_rs1; d.rs2 = f_rs2; end
        7'h63: begin d.itype = 3; d.imm = imm_b; d.rs1 = f_rs1; d.rs2 = f_rs2; end
        7'h37, 7'h17: begin d.itype = 4; d.imm = imm_u; d.rd = f_rd; end
        7'h6F: begin d.itype = 5; d.imm = imm_j; d.rd = f_rd; end
        7'h33: begin d.rd = f_rd; d.rs1 = f_rs1; d.rs2 = f_rs2; end
        7'h3B: if (xlen == 64) begin d.rd = f_rd; d.rs1 = f_rs1; d.rs2 = f_rs2; end
               else d.ill = 1'b1;
        default: d.ill = 1'b1;
      endcase
    end
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every output of both DUTs against the model queue.
  task automatic compare_all();
    dec_t d64, d32;
    bit v;
    logic [31:0] hi;
    logic [63:0] hp;
    v  = (q.size() != 0);
    hi = '0;
    hp = '0;
    if (v) begin
      hi = q[0].inst;
      hp = q[0].pc;
    end
    d64 = ref_decode(hi, 64);
    d32 = ref_decode(hi, 32);
    chk("in_ready64",  64'(b64.in_ready),  64'(q.size() < 2));
    chk("out_valid64", 64'(b64.out_valid), 64'(v));
    chk("opcode64",    64'(b64.opcode),    64'(hi[6:0]));
    chk("funct3_64",   64'(b64.funct3),    64'(hi[14:12]));
    chk("funct7_64",   64'(b64.funct7),    64'(hi[31:25]));
    chk("rd64",        64'(b64.rd),        v ? 64'(d64.rd)  : 64'd0);
    chk("rs1_64",      64'(b64.rs1),       v ? 64'(d64.rs1) : 64'd0);
    chk("rs2_64",      64'(b64.rs2),       v ? 64'(d64.rs2) : 64'd0);
    chk("imm64",       b64.imm,            v ? 64'(d64.imm) : 64'd0);
    chk("imm_type64",  64'(b64.imm_type),  v ? 64'(d64.itype) : 64'd0);
    chk("illegal64",   64'(b64.illegal),   64'(v && d64.ill));
    chk("pc_out64",    b64.pc_out,         hp);
    chk("in_ready32",  64'(b32.in_ready),  64'(q.size() < 2));
    chk("out_valid32", 64'(b32.out_valid), 64'(v));
    chk("opcode32",    64'(b32.opcode),    64'(hi[6:0]));
    chk("funct3_32",   64'(b32.funct3),    64'(hi[14:12]));
    chk("funct7_32",   64'(b32.funct7),    64'(hi[31:25]));
    chk("rd32",        64'(b32.rd),        v ? 64'(d32.rd)  : 64'd0);
    chk("rs1_32",      64'(b32.rs1),       v ? 64'(d32.rs1) : 64'd0);
    chk("rs2_32",      64'(b32.rs2),       v ? 64'(d32.rs2) : 64'd0);
    chk("imm32",       64'(b32.imm),       v ? 64'(d32.imm[31:0]) : 64'd0);
    chk("imm_type32",  64'(b32.imm_type),  v ? 64'(d32.itype) : 64'd0);
    chk("illegal32",   64'(b32.illegal),   64'(v && d32.ill));
    chk("pc_out32",    64'(b32.pc_out),    64'd0);
  endtask

  // One clock: drive inputs, advance the model across the edge, then compare.
  task automatic cyc(input bit r, input bit f, input bit iv, input logic [31:0] ins,
                     input logic [63:0] pc, input bit ordy);
    bit acc, pp;
    int n;
    rst = r;
    flush = f;
    b64.in_valid = iv;       b32.in_valid = iv;
    b64.inst = ins;          b32.inst = ins;
    b64.pc_in = pc;          b32.pc_in = pc[31:0];
    b64.out_ready = ordy;    b32.out_ready = ordy;
    n   = q.size();
    acc = iv && (n < 2);
    pp  = ordy && (n > 0);
    if (r || f) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back('{ins, pc});
    end
    @(negedge clk);
    compare_all();
  endtask

  logic [6:0] ops [12];

  initial begin
    dec_t md;
    logic [31:0] ri;
    logic [63:0] rp;
    int sel;

    ops = '{7'h13, 7'h67, 7'h03, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h1B, 7'h3B};

    // Hand-computed values pinning the reference decoder.
    md = ref_decode(32'hFFF00093, 64);
    chk("pin_i_imm", 64'(md.imm), 64'hFFFF_FFFF_FFFF_FFFF);
    md = ref_decode(32'h008000EF, 64);
    chk("pin_j_imm", 64'(md.imm), 64'd8);
    md = ref_decode(32'hFE000EE3, 64);
    chk("pin_b_imm", 64'(md.imm), 64'hFFFF_FFFF_FFFF_FFFC);
    md = ref_decode(32'h0010009B, 32);
    chk("pin_opimm32_rv32_ill", 64'(md.ill), 64'd1);

    // Reset state.
    cyc(1, 0, 0, 32'h0, 64'h0, 0);
    cyc(1, 0, 0, 32'h0, 64'h0, 0);
    chk("rst_out_valid", 64'(b64.out_valid), 64'd0);
    chk("rst_in_ready",  64'(b64.in_ready),  64'd1);

    // Single-entry latency and immediate formats.
    cyc(0, 0, 1, 32'hFFF00093, 64'h1000, 1);
    chk("lit_i_valid",   64'(b64.out_valid), 64'd1);
    chk("lit_i_imm",     b64.imm,            64'hFFFF_FFFF_FFFF_FFFF);
    chk("lit_i_rd",      64'(b64.rd),        64'd1);
    chk("lit_i_rs1",     64'(b64.rs1),       64'd0);
    chk("lit_i_type",    64'(b64.imm_type),  64'd1);
    chk("lit_i_ill",     64'(b64.illegal),   64'd0);
    chk("lit_i_pc",      b64.pc_out,         64'h1000);
    cyc(0, 0, 1, 32'h008000EF, 64'h1004, 1);
    chk("lit_j_imm",     b64.imm,            64'd8);
    chk("lit_j_rd",      64'(b64.rd),        64'd1);
    chk("lit_j_type",    64'(b64.imm_type),  64'd5);
    cyc(0, 0, 1, 32'hFE000EE3, 64'h1008, 1);
    chk("lit_b_imm",     b64.imm,            64'hFFFF_FFFF_FFFF_FFFC);
    chk("lit_b_type",    64'(b64.imm_type),  64'd3);
    chk("lit_b_rd",      64'(b64.rd),        64'd0);
    cyc(0, 0, 1, 32'h00000000, 64'h100C, 1);
    chk("lit_zero_ill",  64'(b64.illegal),   64'd1);
    chk("lit_zero_imm",  b64.imm,            64'd0);
    cyc(0, 0, 1, 32'h0010009B, 64'h1010, 1);
    chk("lit_w_ill64",   64'(b64.illegal),   64'd0);
    chk("lit_w_imm64",   b64.imm,            64'd1);
    chk("lit_w_ill32",   64'(b32.illegal),   64'd1);
    chk("lit_w_imm32",   64'(b32.imm),       64'd0);
    cyc(0, 0, 1, 32'h12345037, 64'h1014, 1);
    chk("lit_lui_imm32", 64'(b32.imm),       64'h12345000);
    chk("lit_lui_rd32",  64'(b32.rd),        64'd0);
    chk("lit_lui_pc32",  64'(b32.pc_out),    64'd0);
    cyc(0, 0, 0, 32'h0, 64'h0, 1);
    chk("drain_valid",   64'(b64.out_valid), 64'd0);

    // Full FIFO backpressure and ordering.
    cyc(0, 0, 1, 32'h00100093, 64'h2000, 0);
    cyc(0, 0, 1, 32'h00200113, 64'h2004, 0);
    chk("full_in_ready", 64'(b64.in_ready),  64'd0);
    cyc(0, 0, 1, 32'h00300193, 64'h2008, 0);
    chk("full_head_rd",  64'(b64.rd),        64'd1);
    chk("full_in_ready2",64'(b64.in_ready),  64'd0);
    cyc(0, 0, 0, 32'h0, 64'h0, 1);
    chk("pop_in_ready",  64'(b64.in_ready),  64'd1);
    chk("pop_head_rd",   64'(b64.rd),        64'd2);
    cyc(0, 0, 0, 32'h0, 64'h0, 1);
    chk("third_dropped", 64'(b64.out_valid), 64'd0);

    // Flush with a simultaneous offer.
    cyc(0, 0, 1, 32'h00100093, 64'h3000, 0);
    cyc(0, 0, 1, 32'h00200113, 64'h3004, 0);
    cyc(0, 1, 1, 32'h00300193, 64'h3008, 0);
    chk("flush_valid",   64'(b64.out_valid), 64'd0);
    chk("flush_ready",   64'(b64.in_ready),  64'd1);
    cyc(0, 0, 0, 32'h0, 64'h0, 0);
    chk("flush_drop",    64'(b64.out_valid), 64'd0);

    // Reset while full.
    cyc(0, 0, 1, 32'h00100093, 64'h4000, 0);
    cyc(0, 0, 1, 32'hFE000EE3, 64'h4004, 0);
    cyc(1, 0, 1, 32'h00300193, 64'h4008, 0);
    chk("rstf_valid",    64'(b64.out_valid), 64'd0);
    chk("rstf_ready",    64'(b64.in_ready),  64'd1);
    chk("rstf_opcode",   64'(b64.opcode),    64'd0);
    chk("rstf_imm",      b64.imm,            64'd0);
    chk("rstf_pc",       b64.pc_out,         64'd0);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      ri  = $urandom;
      rp  = {$urandom, $urandom};
      sel = int'($urandom_range(0, 15));
      if (sel < 12) ri[6:0] = ops[sel];
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 9) < 7, ri, rp, $urandom_range(0, 9) < 6);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/idu_stage.md
IDU_STAGE -- requirements
Module: idu_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath/immediate width; legal values 32, 64.
REQ-002 SHALL have parameter PASS_PC, default 1; 1 = carry pc alongside instruction, 0 = pc output tied to zero.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  discard all buffered entries.
REQ-006 SHALL have port in_valid  input  1  upstream instruction present.
REQ-007 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-008 SHALL have port inst  input  32  raw RV instruction.
REQ-009 SHALL have port pc_in  input  XLEN  instruction address.
REQ-010 SHALL have port out_valid  output  1  decoded entry at head.
REQ-011 SHALL have port out_ready  input  1  downstream consumes head.
REQ-012 SHALL have port opcode  output  7  inst[6:0] of head.
REQ-013 SHALL have port funct3  output  3; funct7  output  7 (inst[14:12], inst[31:25]).
REQ-014 SHALL have port rs1, rs2, rd  output  5 each  register indices.
REQ-015 SHALL have port imm  output  XLEN  sign-extended immediate.
REQ-016 SHALL have port imm_type  output  3  0 none, 1 I, 2 S, 3 B, 4 U, 5 J.
REQ-017 SHALL have port illegal  output  1  head instruction not decodable.
REQ-018 SHALL have port pc_out  output  XLEN  pc of head.

Function
REQ-019 SHALL hold a 2-entry FIFO of decoded records; decode is combinational on inst, stored at accept.
REQ-020 SHALL assert in_ready exactly when stored count < 2 (registered-count based, no dependency on out_ready).
REQ-021 SHALL accept when in_valid && in_ready; SHALL pop when out_valid && out_ready; both in one cycle leave count unchanged.
REQ-022 SHALL have latency 1: record accepted in cycle N appears at head with out_valid=1 in cycle N+1 if FIFO was empty.
REQ-023 SHALL preserve order; head outputs SHALL stay stable while out_valid && !out_ready.
REQ-024 SHALL decode: OP-IMM 0010011, JALR 1100111, LOAD 0000011, SYSTEM 1110011 -> I-type, imm=sext(inst[31:20]), rd, rs1, rs2=0.
REQ-025 SHALL decode STORE 0100011 -> S-type, imm=sext({inst[31:25],inst[11:7]}), rs1, rs2, rd=0.
REQ-026 SHALL decode BRANCH 1100011 -> B-type, imm=sext({inst[31],inst[7],inst[30:25],inst[11:8],0}), rs1, rs2, rd=0.
REQ-027 SHALL decode LUI 0110111, AUIPC 0010111 -> U-type, imm=sext({inst[31:12],12'b0}) to XLEN, rd, rs1=rs2=0.
REQ-028 SHALL decode JAL 1101111 -> J-type, imm=sext({inst[31],inst[19:12],inst[20],inst[30:21],0}), rd, rs1=rs2=0.
REQ-029 SHALL decode OP 0110011 -> imm_type none, imm=0, rd, rs1, rs2.
REQ-030 SHALL treat OP-IMM-32 0011011 (I-type) and OP-32 0111011 (as OP) as legal only when XLEN=64.
REQ-031 SHALL flag illegal=1 for any other opcode or inst[1:0]!=2'b11; then imm=0, imm_type=0, rs1=rs2=rd=0; entry still flows through handshake.
REQ-032 SHALL pass funct3/funct7/opcode raw for all entries, legal or not.
REQ-033 SHALL, on flush, set count=0 next cycle; a same-cycle accept SHALL be dropped; flush has priority over pop and accept.
REQ-034 SHALL zero pc_out when PASS_PC=0.

Reset
REQ-035 SHALL, while rst=1 at a clock edge, clear count to 0, out_valid=0, in_ready=1 next cycle; rst overrides flush and handshakes.
REQ-036 SHALL drive all head data outputs to 0 while out_valid=0 after reset; reset mid-operation discards both entries.

Verification
REQ-037 SHALL cover: XLEN=64, inst 0xFFF00093 accepted, out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFFFFFFFFFF, rd=1, rs1=0, imm_type=1, illegal=0.
REQ-038 SHALL cover: inst 0x008000EF -> imm=8, rd=1, imm_type=5; inst 0xFE000EE3 -> imm=-4 sext, imm_type=3, rd=0.
REQ-039 SHALL cover: out_ready=0, three back-to-back in_valid -> two accepted, in_ready=0 from third cycle; one pop -> in_ready=1 next cycle, order preserved.
REQ-040 SHALL cover: count=2, flush=1 with in_valid=1 -> next cycle out_valid=0, count=0, dropped input never appears.
REQ-041 SHALL cover: inst 0x00000000 -> illegal=1, imm=0; XLEN=32 with 0x0010009B -> illegal=1; XLEN=32 LUI 0x12345037 -> imm=0x12345000, rd=0.
REQ-042 SHALL cover: rst=1 asserted with count=2 -> next cycle out_valid=0, in_ready=1, all data outputs 0.
